// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read-side stage that absorbs the FIFO's 1-cycle read latency and
// re-presents words as a valid/ready stream through a small skid buffer.
// Optional o_m_last packet framing is enabled by defining FIFO_RD_STREAM_TLAST_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 48,
  parameter int BUF_DEPTH  = 3,
  parameter int PKT_LEN    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_sync,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_data_vld,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  input  logic                  i_m_ready,
  output logic                  o_m_last,
  output logic                  o_err
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [CW:0]   DEPTH    = (CW + 1)'(BUF_DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, err_q, err_d;
  logic                  push, pop, full, wr_en;
  logic [CW:0]           occ;

  // Read issue uses only registered occupancy so consumer ready never reaches o_fifo_rd.
  always_comb begin
    occ       = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
    full      = cnt_q == FULL;
    o_m_valid = cnt_q != '0;
    o_m_data  = buf_q[rd_ptr_q];
    o_fifo_rd = ~i_rst_sync & i_enable & ~i_fifo_empty & (occ < DEPTH);
    push      = i_fifo_data_vld;
    pop       = o_m_valid & i_m_ready;
    wr_en     = push & (~full | pop);
    cnt_d     = (wr_en & ~pop) ? cnt_q + 1'b1 : (~wr_en & pop) ? cnt_q - 1'b1 : cnt_q;
    wr_ptr_d  = wr_en ? (wr_ptr_q == PTR_LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d  = pop ? (rd_ptr_q == PTR_LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    err_d     = err_q | (push & full & ~pop);
    o_err     = err_q;
  end

  // Occupancy, pointers, in-flight tracking and sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_rst_sync) begin
    if (i_rst_sync) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= o_fifo_rd;
      err_q      <= err_d;
    end
  end

  // Skid buffer storage; cleared on reset so the idle stream word reads as zero.
  always_ff @(posedge i_clk or posedge i_rst_sync) begin
    if (i_rst_sync) begin
      for (int k = 0; k < BUF_DEPTH; k++) buf_q[k] <= '0;
    end else if (wr_en) begin
      buf_q[wr_ptr_q] <= i_fifo_data;
    end
  end

`ifdef FIFO_RD_STREAM_TLAST_EN
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);
  logic [BW-1:0] beat_q, beat_d;

  // Beat position within the packet, advanced on every transferred beat.
  always_comb begin
    beat_d   = pop ? (beat_q == BEAT_LAST ? '0 : beat_q + 1'b1) : beat_q;
    o_m_last = o_m_valid & (beat_q == BEAT_LAST);
  end

  // Beat counter register.
  always_ff @(posedge i_clk or posedge i_rst_sync) begin
    if (i_rst_sync) beat_q <= '0;
    else beat_q <= beat_d;
  end
`else
  logic unused_pkt_len;
  assign unused_pkt_len = ^PKT_LEN;
  assign o_m_last       = 1'b0;
`endif
endmodule
